// File: rtl/demux32_1to4_stream.sv
// ----------------------------------------------------------------------------
// demux32_1to4_stream
//
// Registered 1-to-4 stream demultiplexer. One producer offers a word per
// cycle on a valid/ready input; the word is steered by in_sel into one of
// four single-entry holding registers (A..D). Each holding register is
// presented on its own valid/ready output channel, so the four consumers
// can stall independently. Each channel also counts delivered words.
//
// Ports:
//   Clk        rising-edge clock
//   Rst_n      asynchronous active-low reset
//   in_valid   input word present
//   in_ready   block can take the input word this cycle
//   in_data    input word (WIDTH bits)
//   in_sel     destination channel: 0=A, 1=B, 2=C, 3=D
//   outX_data  channel X holding register (registered, not pass-through)
//   out_valid  per-channel valid, bit 0=A .. bit 3=D
//   out_ready  per-channel consumer ready, same bit order
//   cntX       words delivered on channel X, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module demux32_1to4_stream #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [WIDTH-1:0] outA_data,
    output logic [WIDTH-1:0] outB_data,
    output logic [WIDTH-1:0] outC_data,
    output logic [WIDTH-1:0] outD_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNT_W-1:0] cntA,
    output logic [CNT_W-1:0] cntB,
    output logic [CNT_W-1:0] cntC,
    output logic [CNT_W-1:0] cntD
);

    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [CNT_W-1:0] cnt_q  [4];
    logic [CNT_W-1:0] cnt_d  [4];

    logic [3:0] deliverVec;
    logic [3:0] acceptVec;
    logic       accept;

    // Handshake and next-state logic. The selected slot can take a word if
    // it is empty or is being drained this same cycle, which gives full
    // throughput into one channel with no bubble. in_ready deliberately
    // ignores in_valid so the producer can look at it before committing.
    always_comb begin
        deliverVec = valid_q & out_ready;
        in_ready   = !valid_q[in_sel] || out_ready[in_sel];
        accept     = in_valid && in_ready;

        acceptVec = 4'b0000;
        if (accept) begin
            acceptVec[in_sel] = 1'b1;
        end

        // A slot that delivers and accepts on the same edge stays full.
        valid_d = (valid_q & ~deliverVec) | acceptVec;

        for (int i = 0; i < 4; i++) begin
            data_d[i] = acceptVec[i] ? in_data : data_q[i];
            cnt_d[i]  = deliverVec[i] ? (cnt_q[i] + CNT_W'(1)) : cnt_q[i];
        end
    end

    // State registers. Reset drops any held word without counting it as a
    // delivery and clears the data registers and counters.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign out_valid = valid_q;
    assign outA_data = data_q[0];
    assign outB_data = data_q[1];
    assign outC_data = data_q[2];
    assign outD_data = data_q[3];
    assign cntA      = cnt_q[0];
    assign cntB      = cnt_q[1];
    assign cntC      = cnt_q[2];
    assign cntD      = cnt_q[3];

endmodule

// File: doc/demux32_1to4_stream.md
# demux32_1to4_stream

Registered 1-to-4 stream demultiplexer for 32-bit data: accepts one word per cycle on a valid/ready input, routes it by a 2-bit select into one of four single-entry output registers, and presents each on an independent valid/ready output channel. It sits where one producer (e.g. a write-back or result bus) must feed four consumers that can stall independently. It is the steering counterpart of the 4-to-1 select muxes used in the datapath. Each channel also counts delivered words for debug and verification.

## Interface
Parameters:
- WIDTH, 32, data width of input and each output channel.
- CNT_W, 16, width of each per-channel delivered-word counter.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination: 0=A, 1=B, 2=C, 3=D.
- outA_data, outB_data, outC_data, outD_data  output  WIDTH  channel holding registers.
- out_valid  output  4  per-channel valid, bit 0=A … bit 3=D.
- out_ready  input  4  per-channel consumer ready, same bit order.
- cntA, cntB, cntC, cntD  output  CNT_W  words delivered per channel.

## Operation
- Per channel i: holding register data[i], flag valid[i]. out_valid[i] = valid[i]; outX_data = data[i] (registered, not pass-through).
- in_ready = !valid[in_sel] || out_ready[in_sel]. Combinational from in_sel, valid and out_ready. Does not depend on in_valid.
- Accept: in_valid && in_ready. On the next edge, data[in_sel] <= in_data and valid[in_sel] <= 1.
- Deliver on channel i: out_valid[i] && out_ready[i]. On the next edge, valid[i] <= 0 unless the same edge accepts a new word into i. In that case valid[i] stays 1 and data[i] takes the new word.
- Counters: cnt[i] increments by 1 on every delivery on channel i. It wraps modulo 2^CNT_W with no saturation.
- Channels are independent. A stalled channel blocks only inputs addressed to it. Words for other channels continue at full rate.
- Data and in_sel are don't-care when in_valid=0. Non-selected channels' data registers never change.
- data[i] holds its value after delivery until overwritten. Consumers must qualify data with out_valid.

## Timing
- Reset (Rst_n low, asynchronous assert): out_valid=4'b0000, all outX_data=0, all cnt=0. in_ready reads 1 during reset, but no accept occurs while Rst_n is low.
- Reset deassertion takes effect at the first rising edge with Rst_n high.
- Reset mid-operation drops all held words with no delivery. Counters clear.
- Latency: a word accepted at edge N appears with out_valid high after edge N (cycle N+1).
- Throughput: one word per cycle sustained to one channel if that consumer holds out_ready=1. Likewise across rotating channels.
- Simultaneous accept-into-i and deliver-from-i: cnt[i]+1, valid stays 1, new data visible next cycle. No bubble.
- Full channel with out_ready[i]=0: in_ready=0 for in_sel=i, and the input must hold in_valid/in_data/in_sel stable. Deliveries on other channels proceed the same cycle.
- All four deliveries may occur in one cycle. Each counter increments independently.
- Counter wrap: cnt=2^CNT_W−1 plus a delivery gives 0.

## Test plan
- Reset: drive Rst_n low mid-cycle with channels A and C full. Require out_valid=0000 immediately, all data and counters 0. After release, send 0xDEADBEEF to sel=2. Require outC_data=0xDEADBEEF and out_valid=0100 one cycle later.
- Streaming: out_ready=1111, send 0x1,0x2,0x3,0x4 with sel=0,1,2,3 on consecutive cycles. Require each to appear one cycle after acceptance, in_ready held 1, and every cnt=1.
- Back-pressure: out_ready[1]=0, send 0xA to sel=1, then 0xB to sel=1. Require in_ready=0 on the second word and outB_data to stay 0xA. Raise out_ready[1]: 0xB is accepted the same cycle, outB_data=0xB next cycle, cntB=1 then 2.
- Independence: with channel B stalled and full, send 0x55 to sel=3. Require acceptance with in_ready=1 and outD_data=0x55 next cycle.
- Simultaneous deliver+accept on channel A for 5 cycles with data 0x10..0x14. Require out_valid[0] to stay high continuously and cntA=5 after the last delivery.
- Wrap: CNT_W=4, 17 deliveries on channel C. Require cntC=1.
